// File: rtl/red_pitaya_pll_drp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : red_pitaya_pll_drp
//  Description : Sequences read-modify-write accesses on a PLL dynamic
//                reconfiguration port while holding the PLL in reset, then
//                releases reset and waits for the (synchronised) lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_pll_drp #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic [15:0] cmd_mask,
    input  logic        cmd_last,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        pll_rst,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int C_MAX_A = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int C_MAX   = (C_MAX_A > LOCK_TIMEOUT) ? C_MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(C_MAX + 1);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] C_DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HOLD      = 4'd1,
        RD_REQ    = 4'd2,
        RD_WAIT   = 4'd3,
        WR_REQ    = 4'd4,
        WR_WAIT   = 4'd5,
        NEXT      = 4'd6,
        LOCK_WAIT = 4'd7,
        FINISH    = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_lock_s;
    logic [CNT_W-1:0]  r_cnt;
    logic [6:0]        r_addr;
    logic [15:0]       r_data;
    logic [15:0]       r_mask;
    logic [15:0]       r_rdata;
    logic              r_last;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic              w_accept;
    logic              w_set_err;
    logic [1:0]        w_set_code;
    logic              w_counting;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_counting = (r_state == HOLD) || (r_state == RD_WAIT) ||
                        (r_state == WR_WAIT) || (r_state == LOCK_WAIT);

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; an event always takes priority over its timeout
    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        w_set_code  = 2'b00;
        case (r_state)
            IDLE:      if (cmd_valid) w_state_nxt = HOLD;
            HOLD:      if (r_cnt == C_HOLD_LAST) w_state_nxt = RD_REQ;
            RD_REQ:    w_state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (drp_drdy) begin
                    w_state_nxt = WR_REQ;
                end else if (r_cnt == C_DRDY_LAST) begin
                    w_state_nxt = FINISH;
                    w_set_err   = 1'b1;
                    w_set_code  = 2'b01;
                end
            end
            WR_REQ:    w_state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (drp_drdy) begin
                    w_state_nxt = r_last ? LOCK_WAIT : NEXT;
                end else if (r_cnt == C_DRDY_LAST) begin
                    w_state_nxt = FINISH;
                    w_set_err   = 1'b1;
                    w_set_code  = 2'b10;
                end
            end
            NEXT:      if (cmd_valid) w_state_nxt = RD_REQ;
            LOCK_WAIT: begin
                if (r_lock_s) begin
                    w_state_nxt = FINISH;
                end else if (r_cnt == C_LOCK_LAST) begin
                    w_state_nxt = FINISH;
                    w_set_err   = 1'b1;
                    w_set_code  = 2'b11;
                end
            end
            FINISH:    w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Wait counter restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_cnt <= '0;
        else if (w_state_nxt != r_state) r_cnt <= '0;
        else if (w_counting)            r_cnt <= r_cnt + 1'b1;
    end

    // Command latch, read-data capture and sticky error status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_last     <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            if (w_accept) begin
                r_addr <= cmd_addr;
                r_data <= cmd_data;
                r_mask <= cmd_mask;
                r_last <= cmd_last;
            end
            if ((r_state == RD_WAIT) && drp_drdy) r_rdata <= drp_do;
            if (w_accept && (r_state == IDLE)) begin
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
            end else if (w_set_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_set_code;
            end
        end
    end

    // Outputs decoded from state; reset forces IDLE so everything reads 0
    always_comb begin
        cmd_ready = ((r_state == IDLE) || (r_state == NEXT)) && !rst;
        busy      = (r_state != IDLE);
        done      = (r_state == FINISH);
        pll_rst   = (r_state == HOLD) || (r_state == RD_REQ) || (r_state == RD_WAIT) ||
                    (r_state == WR_REQ) || (r_state == WR_WAIT) || (r_state == NEXT);
        drp_den   = (r_state == RD_REQ) || (r_state == WR_REQ);
        drp_dwe   = (r_state == WR_REQ);
        drp_daddr = drp_den ? r_addr : 7'd0;
        drp_di    = (r_state == WR_REQ) ? ((r_rdata & r_mask) | (r_data & ~r_mask)) : 16'd0;
        err       = r_err;
        err_code  = r_err_code;
    end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_pll_drp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_red_pitaya_pll_drp
//  Description : Self-checking bench for red_pitaya_pll_drp
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_pll_drp;

    localparam int RST_HOLD = 4;
    localparam int DRDY_TO  = 64;
    localparam int LOCK_TO  = 100;
    localparam int NEVER    = 1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic [15:0] cmd_mask = '0;
    logic        cmd_last = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        pll_rst;
    logic        pll_locked = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    red_pitaya_pll_drp #(
        .RST_HOLD    (RST_HOLD),
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_last(cmd_last),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .pll_rst(pll_rst), .pll_locked(pll_locked),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the current cycle, produced by the sequence model
    logic        chk_en = 1'b0;
    logic        e_ready, e_busy, e_done, e_pr, e_den, e_dwe, e_err;
    logic [1:0]  e_code;
    logic [6:0]  e_addr;
    logic [15:0] e_di;
    logic        model_err  = 1'b0;
    logic [1:0]  model_code = 2'b00;

    // Observation statistics gathered by the compare process
    int          n_pr = 0, n_done = 0, n_den = 0;
    logic [15:0] last_di = '0;

    // Per-command stimulus plan
    int          gap [8];
    int          rd_d[8];
    int          wr_d[8];
    int          lock_d;
    logic [6:0]  c_addr[8];
    logic [15:0] c_data[8], c_mask[8], c_rd[8];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
            cmp("busy",      {31'd0, busy},      {31'd0, e_busy});
            cmp("done",      {31'd0, done},      {31'd0, e_done});
            cmp("pll_rst",   {31'd0, pll_rst},   {31'd0, e_pr});
            cmp("drp_den",   {31'd0, drp_den},   {31'd0, e_den});
            cmp("drp_dwe",   {31'd0, drp_dwe},   {31'd0, e_dwe});
            cmp("err",       {31'd0, err},       {31'd0, e_err});
            cmp("err_code",  {30'd0, err_code},  {30'd0, e_code});
            if (e_den) cmp("drp_daddr", {25'd0, drp_daddr}, {25'd0, e_addr});
            if (e_dwe) cmp("drp_di",    {16'd0, drp_di},    {16'd0, e_di});
            if (pll_rst) n_pr++;
            if (done)    n_done++;
            if (drp_den) n_den++;
            if (drp_den && drp_dwe) last_di = drp_di;
        end
    end

    task automatic set_exp(input logic rdy, input logic bsy, input logic dn, input logic pr,
                           input logic den, input logic dwe,
                           input logic [6:0] a, input logic [15:0] di);
        e_ready = rdy; e_busy = bsy; e_done = dn; e_pr = pr;
        e_den = den; e_dwe = dwe; e_addr = a; e_di = di;
        e_err = model_err; e_code = model_code;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drp_drdy  = 1'b0;
    endtask

    // Stray drdy pulses in states that must ignore them
    task automatic spur();
        drp_drdy = ($urandom_range(0, 3) == 0);
        drp_do   = 16'($urandom);
    endtask

    task automatic finish_seq(input logic e, input logic [1:0] c);
        if (e) begin
            model_err  = 1'b1;
            model_code = c;
        end
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
        spur();
        pll_locked = 1'b0;
        tick();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    endtask

    task automatic reset_abort();
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        cmp("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmp("rst_busy",      {31'd0, busy},      32'd0);
        cmp("rst_pll_rst",   {31'd0, pll_rst},   32'd0);
        cmp("rst_drp_den",   {31'd0, drp_den},   32'd0);
        cmp("rst_drp_dwe",   {31'd0, drp_dwe},   32'd0);
        cmp("rst_drp_di",    {16'd0, drp_di},    32'd0);
        cmp("rst_done",      {31'd0, done},      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        cmp("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmp("rel_busy",      {31'd0, busy},      32'd0);
        cmp("rel_drp_den",   {31'd0, drp_den},   32'd0);
        model_err  = 1'b0;
        model_code = 2'b00;
        pll_locked = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
        chk_en = 1'b1;
    endtask

    // Walks one command sequence, predicting every cycle from the stimulus plan
    task automatic run_seq(input int ncmd, input bit abort_wr);
        logic [15:0] wv;
        for (int k = 0; k < ncmd; k++) begin
            for (int g = 0; g <= gap[k]; g++) begin
                if (k == 0) set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
                else        set_exp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0);
                spur();
                if (g == gap[k]) begin
                    cmd_valid = 1'b1;
                    cmd_addr  = c_addr[k];
                    cmd_data  = c_data[k];
                    cmd_mask  = c_mask[k];
                    cmd_last  = (k == ncmd - 1);
                end
                tick();
            end
            if (k == 0) begin
                model_err  = 1'b0;
                model_code = 2'b00;
                for (int h = 0; h < RST_HOLD; h++) begin
                    set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0);
                    spur();
                    tick();
                end
            end
            set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c_addr[k], 16'd0);
            spur();
            tick();
            for (int i = 0; i < NEVER; i++) begin
                set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0);
                drp_do = 16'($urandom);
                if (i == rd_d[k]) begin
                    drp_drdy = 1'b1;
                    drp_do   = c_rd[k];
                end
                tick();
                if (i == rd_d[k]) break;
                if (i == DRDY_TO - 1) begin
                    finish_seq(1'b1, 2'b01);
                    return;
                end
            end
            wv = (c_rd[k] & c_mask[k]) | (c_data[k] & ~c_mask[k]);
            set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, c_addr[k], wv);
            spur();
            tick();
            for (int i = 0; i < NEVER; i++) begin
                if (abort_wr && i == 3) begin
                    reset_abort();
                    return;
                end
                set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0);
                if (i == wr_d[k]) drp_drdy = 1'b1;
                tick();
                if (i == wr_d[k]) break;
                if (i == DRDY_TO - 1) begin
                    finish_seq(1'b1, 2'b10);
                    return;
                end
            end
        end
        // Lock is seen two clocks after it is driven, through the synchroniser
        for (int i = 0; i < NEVER; i++) begin
            set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
            spur();
            if (i == lock_d) pll_locked = 1'b1;
            tick();
            if (i == lock_d + 2) begin
                finish_seq(1'b0, 2'b00);
                return;
            end
            if (i == LOCK_TO - 1) begin
                finish_seq(1'b1, 2'b11);
                return;
            end
        end
    endtask

    task automatic fill_rand(input bit allow_to);
        for (int k = 0; k < 8; k++) begin
            gap[k]    = $urandom_range(0, 4);
            c_addr[k] = 7'($urandom);
            c_data[k] = 16'($urandom);
            c_mask[k] = 16'($urandom);
            c_rd[k]   = 16'($urandom);
            rd_d[k]   = (allow_to && $urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 6);
            wr_d[k]   = (allow_to && $urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 6);
        end
        lock_d = (allow_to && $urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 12);
    endtask

    initial begin
        int s_pr, s_done, s_den;

        // Outputs while reset is held
        #3;
        cmp("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmp("reset_busy",      {31'd0, busy},      32'd0);
        cmp("reset_pll_rst",   {31'd0, pll_rst},   32'd0);
        cmp("reset_den",       {31'd0, drp_den},   32'd0);
        cmp("reset_err",       {31'd0, err},       32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
        chk_en = 1'b1;
        tick();
        tick();

        // Single command, read returns FFFF, lock 10 cycles after reset release
        fill_rand(1'b0);
        gap[0] = 1; c_addr[0] = 7'h08; c_data[0] = 16'h1041; c_mask[0] = 16'h1000;
        c_rd[0] = 16'hFFFF; rd_d[0] = 1; wr_d[0] = 1; lock_d = 10;
        s_pr = n_pr; s_done = n_done;
        run_seq(1, 1'b0);
        tick();
        cmp("single_di",      {16'd0, last_di}, 32'h1041);
        cmp("single_pr_cyc",  n_pr - s_pr, 32'd10);
        cmp("single_done",    n_done - s_done, 32'd1);
        cmp("single_err",     {31'd0, err}, 32'd0);

        // Three commands with 5-cycle gaps in NEXT
        fill_rand(1'b0);
        for (int k = 0; k < 3; k++) begin
            gap[k] = (k == 0) ? 0 : 5; rd_d[k] = 0; wr_d[k] = 0;
        end
        lock_d = 3;
        s_pr = n_pr; s_done = n_done; s_den = n_den;
        run_seq(3, 1'b0);
        tick();
        cmp("multi_pr_cyc", n_pr - s_pr, 32'd28);
        cmp("multi_den",    n_den - s_den, 32'd6);
        cmp("multi_done",   n_done - s_done, 32'd1);

        // Read drdy never arrives
        fill_rand(1'b0);
        rd_d[0] = NEVER;
        s_done = n_done;
        run_seq(1, 1'b0);
        tick();
        cmp("rdto_err",  {31'd0, err}, 32'd1);
        cmp("rdto_code", {30'd0, err_code}, 32'd1);
        cmp("rdto_done", n_done - s_done, 32'd1);

        // Lock never asserts, then a clean sequence clears the error
        fill_rand(1'b0);
        lock_d = NEVER;
        run_seq(2, 1'b0);
        tick();
        cmp("lockto_err",  {31'd0, err}, 32'd1);
        cmp("lockto_code", {30'd0, err_code}, 32'd3);
        fill_rand(1'b0);
        run_seq(1, 1'b0);
        tick();
        cmp("clear_err",  {31'd0, err}, 32'd0);
        cmp("clear_code", {30'd0, err_code}, 32'd0);

        // Write drdy exactly on the timeout cycle
        fill_rand(1'b0);
        wr_d[0] = DRDY_TO - 1; lock_d = 2;
        run_seq(1, 1'b0);
        tick();
        cmp("edge_err", {31'd0, err}, 32'd0);

        // Reset during a write wait
        fill_rand(1'b0);
        wr_d[0] = NEVER;
        s_den = n_den;
        run_seq(2, 1'b1);
        for (int c = 0; c < 4; c++) tick();
        cmp("abort_den", n_den - s_den, 32'd2);

        // Randomized sequences
        for (int r = 0; r < 20; r++) begin
            fill_rand(1'b1);
            run_seq($urandom_range(1, 4), 1'b0);
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/red_pitaya_pll_drp.md
RED_PITAYA_PLL_DRP -- requirements
Module: red_pitaya_pll_drp

Interface
REQ-001 SHALL have parameter RST_HOLD, default 4, meaning cycles pll_rst is held before the first DRP access.
REQ-002 SHALL have parameter DRDY_TIMEOUT, default 64, meaning max cycles waited for drp_drdy per access.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, meaning max cycles waited for synchronised lock after reset release.
REQ-004 SHALL have port: clk  in  1  single clock; all logic in this domain.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: cmd_valid in 1, cmd_ready out 1  command handshake.
REQ-007 SHALL have ports: cmd_addr in 7, cmd_data in 16, cmd_mask in 16 (1 = keep old bit), cmd_last in 1 (final command of a sequence).
REQ-008 SHALL have ports: drp_daddr out 7, drp_den out 1, drp_dwe out 1, drp_di out 16, drp_do in 16, drp_drdy in 1  PLL dynamic-reconfiguration port.
REQ-009 SHALL have ports: pll_rst out 1 (PLL reset), pll_locked in 1 (PLL lock, asynchronous).
REQ-010 SHALL have ports: busy out 1, done out 1, err out 1, err_code out 2  status.

Function
REQ-011 SHALL pass pll_locked through a 2-flop synchroniser; only the synchronised value (lock_s) is used.
REQ-012 SHALL implement states IDLE, HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, LOCK_WAIT, FINISH.
REQ-013 SHALL drive cmd_ready = 1 only in IDLE and NEXT; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge, latching addr/data/mask/last.
REQ-014 IDLE accept: clear err and err_code, set busy = 1, set pll_rst = 1, go to HOLD.
REQ-015 HOLD: stay exactly RST_HOLD cycles, then go to RD_REQ.
REQ-016 RD_REQ: one cycle with drp_den = 1, drp_dwe = 0, drp_daddr = latched addr; then RD_WAIT.
REQ-017 RD_WAIT: on drp_drdy, capture drp_do and go to WR_REQ; drp_drdy in any other state is ignored.
REQ-018 WR_REQ: one cycle with drp_den = 1, drp_dwe = 1, drp_daddr = latched addr, drp_di = (captured_do AND mask) OR (data AND NOT mask); then WR_WAIT.
REQ-019 WR_WAIT: on drp_drdy go to LOCK_WAIT if latched last = 1, else to NEXT.
REQ-020 drp_den SHALL be high for exactly one cycle per access; drp_dwe SHALL be 0 whenever drp_den = 0.
REQ-021 NEXT: pll_rst stays 1, no timeout; accepting a command goes to RD_REQ (no HOLD).
REQ-022 Wait counter SHALL clear on entry to RD_WAIT/WR_WAIT/LOCK_WAIT; timeout fires when DRDY_TIMEOUT (or LOCK_TIMEOUT) cycles elapse without the event.
REQ-023 Event and timeout in the same cycle: event wins, no error.
REQ-024 Timeout codes: RD_WAIT -> 2'b01, WR_WAIT -> 2'b10, LOCK_WAIT -> 2'b11; on timeout set err = 1, load err_code, go to FINISH.
REQ-025 LOCK_WAIT: pll_rst = 0 from state entry; lock_s = 1 goes to FINISH with no error.
REQ-026 FINISH: one cycle, done = 1, pll_rst = 0; next cycle busy = 0 and state IDLE.
REQ-027 err and err_code SHALL remain stable until the next IDLE accept.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 While rst = 1, SHALL force state IDLE, synchroniser flops 0, and all outputs 0 (cmd_ready becomes 1 on the first cycle after release).
REQ-030 Reset mid-sequence SHALL abort immediately: pll_rst = 0, drp_den = 0, no partial retry after release.

Verification
REQ-031 Single cmd addr 7'h08, data 16'h1041, mask 16'h1000, last = 1; DRP model returns 16'hFFFF after 2 cycles; lock rises 10 cycles after pll_rst falls -> drp_di = 16'h1041, pll_rst high RST_HOLD+access cycles, done pulse, err = 0.
REQ-032 Three cmds with last on the third, cmd_valid gapped 5 cycles in NEXT -> three read/write pairs, pll_rst held high throughout, one HOLD only, one done pulse.
REQ-033 DRP model never asserts drdy on read -> after 64 cycles in RD_WAIT, err = 1, err_code = 2'b01, pll_rst = 0, done pulse.
REQ-034 Lock never asserts, LOCK_TIMEOUT = 100 -> err_code = 2'b11 after 100 cycles; a following good sequence clears err.
REQ-035 drdy arrives exactly on the timeout cycle in WR_WAIT -> no error, sequence continues.
REQ-036 rst asserted during WR_WAIT -> outputs 0 asynchronously; after release cmd_ready = 1, busy = 0, drp_den stays 0.
